// File: rtl/rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter
//
// N-way round-robin arbiter with hold-until-release ownership. A granted
// requester keeps the grant for as long as it holds its request. If another
// requester is waiting, the tenure is capped at MAX_HOLD consecutive cycles,
// so no requester can be starved. All outputs are registered, and there is no
// combinational path from req to gnt.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous, active-low reset
//   req       : request vector, bit i = requester i
//   gnt       : registered grant vector, one-hot or all-zero
//   gnt_valid : registered, equals |gnt
//   gnt_idx   : index of the set gnt bit; holds its last value while idle
//   preempt   : one-cycle pulse, high while a timeout-forced new grant is shown
// ----------------------------------------------------------------------------
module rr_grant_arbiter #(
   parameter int N        = 4,
   parameter int IDXW     = $clog2(N),
   parameter int MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [IDXW-1:0] gnt_idx,
   output logic            preempt
);

   localparam int CNTW = 8;

   typedef enum logic {IDLE, OWN} state_t;

   state_t          state;
   logic [IDXW-1:0] ptr;
   logic [CNTW-1:0] hold_cnt;

   state_t          state_nxt;
   logic [N-1:0]    gnt_nxt;
   logic [IDXW-1:0] idx_nxt;
   logic [IDXW-1:0] ptr_nxt;
   logic [CNTW-1:0] cnt_nxt;
   logic            pre_nxt;

   logic            win_found;
   logic [IDXW-1:0] win_idx;
   logic [N-1:0]    others;

   // First set bit of r, searching p, p+1, ..., N-1, 0, ..., p-1.
   // The result is packed as {found, index}.
   function automatic logic [IDXW:0] pick(input logic [N-1:0] r, input logic [IDXW-1:0] p);
      logic            found;
      logic [IDXW-1:0] w;
      logic [IDXW-1:0] k;
      found = 1'b0;
      w     = '0;
      for (int i = 0; i < N; i++) begin
         k = IDXW'((int'(p) + i) % N);
         if (!found && r[k]) begin
            found = 1'b1;
            w     = k;
         end
      end
      return {found, w};
   endfunction

   // Pointer advance, modulo N.
   function automatic logic [IDXW-1:0] inc_mod(input logic [IDXW-1:0] i);
      return (i == IDXW'(N - 1)) ? '0 : i + IDXW'(1);
   endfunction

   // Tenure counter increment, saturating at MAX_HOLD.
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
      return (c >= CNTW'(MAX_HOLD)) ? c : c + CNTW'(1);
   endfunction

   assign {win_found, win_idx} = pick(req, ptr);

   // Requests other than the current owner's.
   assign others = req & ~(N'(1) << gnt_idx);

   always_comb begin
      state_nxt = state;
      gnt_nxt   = '0;
      idx_nxt   = gnt_idx;
      ptr_nxt   = ptr;
      cnt_nxt   = hold_cnt;
      pre_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt = OWN;
               gnt_nxt   = N'(1) << win_idx;
               idx_nxt   = win_idx;
               ptr_nxt   = inc_mod(win_idx);
               cnt_nxt   = CNTW'(1);
            end
         end
         OWN: begin
            if (!req[gnt_idx]) begin
               // The owner released the grant. Hand it over at the same edge,
               // or go idle if nobody else is asking.
               if (win_found) begin
                  gnt_nxt = N'(1) << win_idx;
                  idx_nxt = win_idx;
                  ptr_nxt = inc_mod(win_idx);
                  cnt_nxt = CNTW'(1);
               end else begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end else if ((|others) && (hold_cnt == CNTW'(MAX_HOLD))) begin
               // Timeout. ptr already points one past the owner, so the owner is
               // the last candidate and cannot win while another request exists.
               gnt_nxt = N'(1) << win_idx;
               idx_nxt = win_idx;
               ptr_nxt = inc_mod(win_idx);
               cnt_nxt = CNTW'(1);
               pre_nxt = 1'b1;
            end else begin
               gnt_nxt = gnt;
               cnt_nxt = sat_inc(hold_cnt);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         preempt   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= cnt_nxt;
         gnt       <= gnt_nxt;
         gnt_valid <= |gnt_nxt;
         gnt_idx   <= idx_nxt;
         preempt   <= pre_nxt;
      end
   end

   a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
      else $error("rr_grant_arbiter: gnt is not onehot0");

   a_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt))
      else $error("rr_grant_arbiter: gnt_valid disagrees with gnt");

   a_preempt: assert property (@(posedge clk) disable iff (!rst_n) preempt |-> $past(gnt_valid))
      else $error("rr_grant_arbiter: preempt without a previous owner");

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_arbiter
//
// Directed bench for rr_grant_arbiter (N=4, MAX_HOLD=8). A behavioural
// ownership model tracks the owner, its tenure, and the rotation pointer. The
// DUT outputs are compared against the model on every falling edge, and
// hand-computed literal expectations at key points pin the model itself.
// ----------------------------------------------------------------------------
module tb_rr_grant_arbiter;

   localparam int N    = 4;
   localparam int IDXW = 2;
   localparam int MAXH = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N-1:0]    gnt;
   logic            gnt_valid;
   logic [IDXW-1:0] gnt_idx;
   logic            preempt;

   int total = 0;
   int bad   = 0;

   // Behavioural model state.
   int m_owner = -1;   // -1 means no owner
   int m_ptr   = 0;    // next requester with top priority
   int m_ten   = 0;    // cycles the current owner has held the grant
   int m_idx   = 0;    // last granted index
   bit m_pre   = 1'b0;

   rr_grant_arbiter #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAXH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns the first requester in rotation order starting at 'start', or -1.
   function automatic int rr_search(input logic [N-1:0] r, input int start);
      for (int i = 0; i < N; i++) begin
         if (r[(start + i) % N]) return (start + i) % N;
      end
      return -1;
   endfunction

   task automatic model_grant(input int w, input bit pre);
      m_owner = w;
      m_idx   = w;
      m_ptr   = (w + 1) % N;
      m_ten   = 1;
      m_pre   = pre;
   endtask

   // Model: one ownership decision per rising edge. It is reset at once when
   // rst_n falls.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_ten = 0; m_idx = 0; m_pre = 1'b0;
         end else begin
            int  w;
            bit  rivals;
            m_pre = 1'b0;
            w     = rr_search(req, m_ptr);
            if (m_owner < 0) begin
               if (w >= 0) model_grant(w, 1'b0);
            end else begin
               rivals = 1'b0;
               for (int j = 0; j < N; j++) if (j != m_owner && req[j]) rivals = 1'b1;
               if (!req[m_owner]) begin
                  if (w >= 0) model_grant(w, 1'b0);
                  else begin
                     m_owner = -1;
                     m_ten   = 0;
                  end
               end else if (rivals && m_ten == MAXH) begin
                  model_grant(w, 1'b1);
               end else if (m_ten < MAXH) begin
                  m_ten++;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         check("gnt",       32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
         check("gnt_idx",   32'(gnt_idx),   32'(m_idx));
         check("preempt",   32'(preempt),   32'(m_pre));
      end
   end

   // Advance one edge. Outputs of that edge are settled, and inputs for the next
   // edge may be driven.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   localparam int ORDER [5] = '{0, 1, 2, 3, 0};

   initial begin
      // Reset with all requests asserted.
      rst_n = 1'b0;
      req   = 4'b1111;
      tick();
      tick();
      check("rst_gnt",   32'(gnt),       32'd0);
      check("rst_valid", 32'(gnt_valid), 32'd0);
      check("rst_idx",   32'(gnt_idx),   32'd0);
      check("rst_pre",   32'(preempt),   32'd0);
      rst_n = 1'b1;
      req   = 4'b0000;
      tick();
      tick();
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_idx", 32'(gnt_idx), 32'd0);

      // Rotation. Each owner holds for two cycles, then drops its request for one.
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         check("rot_owner", 32'(gnt), 32'd1 << ORDER[k]);
         check("rot_valid", 32'(gnt_valid), 32'd1);
         tick();
         req = 4'b1111 & ~(4'b0001 << ORDER[k]);
         tick();
         req = 4'b1111;
      end
      req = 4'b0000;
      tick();
      tick();

      // Direct hand-off from owner 1 to owner 2.
      req = 4'b0010;
      tick();
      check("ho_own1", 32'(gnt), 32'h2);
      req = 4'b0110;
      tick();
      check("ho_hold1", 32'(gnt), 32'h2);
      req = 4'b0100;
      tick();
      check("ho_gnt2", 32'(gnt), 32'h4);
      check("ho_valid", 32'(gnt_valid), 32'd1);
      check("ho_idx", 32'(gnt_idx), 32'd2);
      req = 4'b0000;
      tick();
      check("ho_release", 32'(gnt), 32'd0);
      check("ho_idx_hold", 32'(gnt_idx), 32'd2);

      // Timeout preemption with two requesters held constant.
      req = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("to_own0", 32'(gnt), 32'h1);
         check("to_nopre0", 32'(preempt), 32'd0);
      end
      tick();
      check("to_pre1_gnt", 32'(gnt), 32'h2);
      check("to_pre1", 32'(preempt), 32'd1);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("to_own1", 32'(gnt), 32'h2);
         check("to_nopre1", 32'(preempt), 32'd0);
      end
      tick();
      check("to_back0", 32'(gnt), 32'h1);
      check("to_pre0", 32'(preempt), 32'd1);
      req = 4'b0000;
      tick();

      // A sole requester is never preempted.
      req = 4'b1000;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("sole_gnt", 32'(gnt), 32'h8);
         check("sole_pre", 32'(preempt), 32'd0);
      end
      req = 4'b0000;
      tick();

      // Asynchronous reset in the middle of a tenure.
      req = 4'b0100;
      tick();
      tick();
      check("ar_before", 32'(gnt), 32'h4);
      #1 rst_n = 1'b0;
      #1;
      check("ar_gnt", 32'(gnt), 32'd0);
      check("ar_valid", 32'(gnt_valid), 32'd0);
      check("ar_idx", 32'(gnt_idx), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("ar_regrant", 32'(gnt), 32'h4);
      check("ar_regrant_idx", 32'(gnt_idx), 32'd2);
      req = 4'b0000;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
